// File: rtl/crossbar_cmd_gen_seq_pkg.sv
// Shared types and helpers for the crossbar command generator.
// Holds the default sizes, the FSM encoding and the command bit-index helper.
package crossbar_cmd_gen_seq_pkg;

    localparam int N_IN_DEFAULT  = 16;
    localparam int N_OUT_DEFAULT = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Bit position of (input i, output j) in a flattened command/mask
    function automatic int cmd_idx(input int i, input int j, input int n_out);
        return i * n_out + j;
    endfunction

endpackage

// File: rtl/crossbar_cmd_gen_seq_if.sv
// Batch request / one-hot command bundle of the crossbar command generator.
// The master side feeds batches and consumes commands; the slave is the generator.
interface crossbar_cmd_gen_seq_if
    import crossbar_cmd_gen_seq_pkg::*;
#(
    parameter int NUM_INPUT_DATA  = N_IN_DEFAULT,
    parameter int NUM_OUTPUT_DATA = N_OUT_DEFAULT
) ();
    localparam int TOTAL_COMMAND = NUM_INPUT_DATA * NUM_OUTPUT_DATA;

    logic                      i_req_valid;
    logic [TOTAL_COMMAND-1:0]  i_req_mask;
    logic                      o_req_ready;
    logic                      i_out_ready;
    logic [TOTAL_COMMAND-1:0]  o_cmd;
    logic                      o_cmd_valid;
    logic [NUM_INPUT_DATA-1:0] o_src_grant;
    logic                      o_batch_done;
    logic                      o_busy;

    modport master (
        output i_req_valid, i_req_mask, i_out_ready,
        input  o_req_ready, o_cmd, o_cmd_valid, o_src_grant,
        input  o_batch_done, o_busy
    );

    modport slave (
        input  i_req_valid, i_req_mask, i_out_ready,
        output o_req_ready, o_cmd, o_cmd_valid, o_src_grant,
        output o_batch_done, o_busy
    );
endinterface

// File: rtl/crossbar_cmd_gen_seq_rr_conflict_arbiter.sv
// Round-robin scan that grants whole pending rows whose outputs are still free.
// Rows are taken atomically; the pointer advances past the first row granted.
module rr_conflict_arbiter
    import crossbar_cmd_gen_seq_pkg::*;
#(
    parameter int NUM_INPUT_DATA  = N_IN_DEFAULT,
    parameter int NUM_OUTPUT_DATA = N_OUT_DEFAULT,
    localparam int TOTAL_COMMAND  = NUM_INPUT_DATA * NUM_OUTPUT_DATA,
    localparam int PTR_WIDTH      = $clog2(NUM_INPUT_DATA)
) (
    input  logic [TOTAL_COMMAND-1:0]  pending,
    input  logic [PTR_WIDTH-1:0]      rr_ptr,
    output logic [NUM_INPUT_DATA-1:0] grant,
    output logic [TOTAL_COMMAND-1:0]  granted_cmd,
    output logic [PTR_WIDTH-1:0]      next_ptr
);
    logic [NUM_OUTPUT_DATA-1:0] used;
    logic [NUM_OUTPUT_DATA-1:0] row;
    logic [PTR_WIDTH-1:0]       idx;
    logic                       found;
    int                         base;

    always_comb begin
        grant       = '0;
        granted_cmd = '0;
        next_ptr    = rr_ptr;
        used        = '0;
        row         = '0;
        idx         = '0;
        found       = 1'b0;
        base        = 0;
        for (int k = 0; k < NUM_INPUT_DATA; k++) begin
            // Pointer width matches the input count, so the add wraps mod N
            idx  = rr_ptr + PTR_WIDTH'(k);
            base = cmd_idx(int'(idx), 0, NUM_OUTPUT_DATA);
            row  = pending[base +: NUM_OUTPUT_DATA];
            if ((row != '0) && ((row & used) == '0)) begin
                grant[idx]                          = 1'b1;
                granted_cmd[base +: NUM_OUTPUT_DATA] = row;
                used                                = used | row;
                if (!found) begin
                    next_ptr = idx + PTR_WIDTH'(1);
                    found    = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/crossbar_cmd_gen_seq.sv
// Accepts batches of per-input destination masks and emits conflict-free
// one-hot crossbar commands, serialising output conflicts round-robin.
module crossbar_cmd_gen_seq
    import crossbar_cmd_gen_seq_pkg::*;
#(
    parameter int NUM_INPUT_DATA  = N_IN_DEFAULT,
    parameter int NUM_OUTPUT_DATA = N_OUT_DEFAULT,
    localparam int TOTAL_COMMAND  = NUM_INPUT_DATA * NUM_OUTPUT_DATA,
    localparam int PTR_WIDTH      = $clog2(NUM_INPUT_DATA)
) (
    input  logic                   CLK,
    input  logic                   rst,
    crossbar_cmd_gen_seq_if.slave  bus
);
    state_t                    state, state_n;
    logic [TOTAL_COMMAND-1:0]  pending, pending_n;
    logic [PTR_WIDTH-1:0]      rr_ptr, ptr_n;
    logic [TOTAL_COMMAND-1:0]  cmd_q, cmd_n;
    logic                      valid_q, valid_n;
    logic [NUM_INPUT_DATA-1:0] src_q, src_n;
    logic                      done_q, done_n;

    logic [NUM_INPUT_DATA-1:0] grant;
    logic [TOTAL_COMMAND-1:0]  granted_cmd;
    logic [PTR_WIDTH-1:0]      next_ptr;

    rr_conflict_arbiter #(
        .NUM_INPUT_DATA (NUM_INPUT_DATA),
        .NUM_OUTPUT_DATA(NUM_OUTPUT_DATA)
    ) u_arb (
        .pending    (pending),
        .rr_ptr     (rr_ptr),
        .grant      (grant),
        .granted_cmd(granted_cmd),
        .next_ptr   (next_ptr)
    );

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pending <= '0;
            rr_ptr  <= '0;
            cmd_q   <= '0;
            valid_q <= 1'b0;
            src_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            rr_ptr  <= ptr_n;
            cmd_q   <= cmd_n;
            valid_q <= valid_n;
            src_q   <= src_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        pending_n = pending;
        ptr_n     = rr_ptr;
        cmd_n     = '0;
        valid_n   = 1'b0;
        src_n     = '0;
        done_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.i_req_valid) begin
                    pending_n = bus.i_req_mask;
                    state_n   = ISSUE;
                end
            end
            ISSUE: begin
                if (pending == '0) begin
                    // Empty batch: close it without issuing anything
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (bus.i_out_ready && (grant != '0)) begin
                    cmd_n     = granted_cmd;
                    src_n     = grant;
                    valid_n   = 1'b1;
                    pending_n = pending & ~granted_cmd;
                    ptr_n     = next_ptr;
                    if (pending_n == '0) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.o_req_ready  = (state == IDLE);
    assign bus.o_busy       = (state == ISSUE);
    assign bus.o_cmd        = cmd_q;
    assign bus.o_cmd_valid  = valid_q;
    assign bus.o_src_grant  = src_q;
    assign bus.o_batch_done = done_q;
endmodule

// File: tb/tb_crossbar_cmd_gen_seq.sv
// Directed bench for crossbar_cmd_gen_seq with hand-computed expectations.
// Default 16x16 configuration; rr_ptr is tracked through the grant order.
module tb_crossbar_cmd_gen_seq;
    import crossbar_cmd_gen_seq_pkg::*;

    logic CLK = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    logic [255:0] perm_mask;
    logic [255:0] conf_mask;
    logic [255:0] mc_mask;

    always #5 CLK = ~CLK;

    crossbar_cmd_gen_seq_if #(.NUM_INPUT_DATA(16), .NUM_OUTPUT_DATA(16)) bus ();

    crossbar_cmd_gen_seq #(
        .NUM_INPUT_DATA (16),
        .NUM_OUTPUT_DATA(16)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [255:0] row5(input int idx);
        logic [255:0] r;
        r = 256'h20;
        return r << (idx * 16);
    endfunction

    task automatic chk_cmd(input string tag, input logic [15:0] g,
                           input logic [255:0] c, input logic d);
        chk({tag, "_valid"}, 256'(bus.o_cmd_valid), 256'(1'b1));
        chk({tag, "_grant"}, 256'(bus.o_src_grant), 256'(g));
        chk({tag, "_cmd"}, 256'(bus.o_cmd), c);
        chk({tag, "_done"}, 256'(bus.o_batch_done), 256'(d));
    endtask

    initial begin
        perm_mask = '0;
        conf_mask = '0;
        mc_mask   = '0;
        for (int i = 0; i < 16; i++) perm_mask[i*16 + (15 - i)] = 1'b1;
        for (int i = 0; i < 4; i++) conf_mask[i*16 + 5] = 1'b1;
        mc_mask[15:0]  = 16'h0003;
        mc_mask[31:16] = 16'h0002;
        mc_mask[47:32] = 16'h0100;

        bus.i_req_valid = 1'b0;
        bus.i_req_mask  = '0;
        bus.i_out_ready = 1'b1;

        #3;
        chk("rst_valid", 256'(bus.o_cmd_valid), 256'(0));
        chk("rst_cmd", 256'(bus.o_cmd), 256'(0));
        chk("rst_grant", 256'(bus.o_src_grant), 256'(0));
        chk("rst_done", 256'(bus.o_batch_done), 256'(0));
        chk("rst_busy", 256'(bus.o_busy), 256'(0));
        chk("rst_ready", 256'(bus.o_req_ready), 256'(1));
        #9 rst = 1'b1;
        tick();

        // Full conflict, rr_ptr=0: grants 1,2,4,8
        bus.i_req_mask  = conf_mask;
        bus.i_req_valid = 1'b1;
        tick();
        bus.i_req_valid = 1'b0;
        chk("conf_busy", 256'(bus.o_busy), 256'(1));
        chk("conf_lat", 256'(bus.o_cmd_valid), 256'(0));
        for (int g = 0; g < 4; g++) begin
            tick();
            chk_cmd($sformatf("conf%0d", g), 16'(1 << g), row5(g), g == 3);
        end
        tick();
        chk("conf_end_valid", 256'(bus.o_cmd_valid), 256'(0));
        chk("conf_end_busy", 256'(bus.o_busy), 256'(0));

        // Permutation, rr_ptr=4 -> 5 afterwards
        bus.i_req_mask  = perm_mask;
        bus.i_req_valid = 1'b1;
        tick();
        bus.i_req_valid = 1'b0;
        tick();
        chk_cmd("perm", 16'hFFFF, perm_mask, 1'b1);
        chk("perm_ready", 256'(bus.o_req_ready), 256'(1));
        tick();
        chk("perm_after", 256'(bus.o_cmd_valid), 256'(0));

        // Multicast overlap, rr_ptr=5: grant 0x5 then 0x2; rr_ptr -> 2
        bus.i_req_mask  = mc_mask;
        bus.i_req_valid = 1'b1;
        tick();
        bus.i_req_valid = 1'b0;
        tick();
        chk_cmd("mc1", 16'h0005, mc_mask & ~(256'h2 << 16), 1'b0);
        tick();
        chk_cmd("mc2", 16'h0002, 256'h2 << 16, 1'b1);

        // Conflict with stall, rr_ptr=2: grants 4,8,1,2; rr_ptr -> 2
        bus.i_req_mask  = conf_mask;
        bus.i_req_valid = 1'b1;
        tick();
        bus.i_req_valid = 1'b0;
        tick();
        chk_cmd("st0", 16'h0004, row5(2), 1'b0);
        bus.i_out_ready = 1'b0;
        tick();
        chk("st_stall1", 256'(bus.o_cmd_valid), 256'(0));
        tick();
        chk("st_stall2", 256'(bus.o_cmd_valid), 256'(0));
        chk("st_stall_cmd", 256'(bus.o_cmd), 256'(0));
        chk("st_stall_busy", 256'(bus.o_busy), 256'(1));
        bus.i_out_ready = 1'b1;
        tick();
        chk_cmd("st1", 16'h0008, row5(3), 1'b0);
        tick();
        chk_cmd("st2", 16'h0001, row5(0), 1'b0);
        tick();
        chk_cmd("st3", 16'h0002, row5(1), 1'b1);

        // Empty batch then permutation back to back; rr_ptr -> 3
        bus.i_req_mask  = '0;
        bus.i_req_valid = 1'b1;
        tick();
        bus.i_req_mask = perm_mask;
        tick();
        chk("empty_done", 256'(bus.o_batch_done), 256'(1));
        chk("empty_valid", 256'(bus.o_cmd_valid), 256'(0));
        chk("empty_ready", 256'(bus.o_req_ready), 256'(1));
        tick();
        bus.i_req_valid = 1'b0;
        chk("b2b_busy", 256'(bus.o_busy), 256'(1));
        tick();
        chk_cmd("b2b_perm", 16'hFFFF, perm_mask, 1'b1);

        // Conflict from rr_ptr=3, reset after the second command
        bus.i_req_mask  = conf_mask;
        bus.i_req_valid = 1'b1;
        tick();
        bus.i_req_valid = 1'b0;
        tick();
        chk_cmd("rb0", 16'h0008, row5(3), 1'b0);
        tick();
        chk_cmd("rb1", 16'h0001, row5(0), 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("mr_valid", 256'(bus.o_cmd_valid), 256'(0));
        chk("mr_cmd", 256'(bus.o_cmd), 256'(0));
        chk("mr_grant", 256'(bus.o_src_grant), 256'(0));
        chk("mr_done", 256'(bus.o_batch_done), 256'(0));
        chk("mr_busy", 256'(bus.o_busy), 256'(0));
        chk("mr_ready", 256'(bus.o_req_ready), 256'(1));
        #3 rst = 1'b1;
        tick();
        chk("mr_no_done", 256'(bus.o_batch_done), 256'(0));
        chk("mr_ready2", 256'(bus.o_req_ready), 256'(1));
        bus.i_req_valid = 1'b1;
        tick();
        bus.i_req_valid = 1'b0;
        tick();
        chk_cmd("ar0", 16'h0001, row5(0), 1'b0);
        tick();
        chk_cmd("ar1", 16'h0002, row5(1), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/crossbar_cmd_gen_seq.md
Name: crossbar_cmd_gen_seq

Overview:
- Producer side of the crossbar one-hot command interface: accepts a batch of per-input destination masks and issues a sequence of conflict-free one-hot crossbar commands.
- Serializes output conflicts (two inputs targeting the same output) over multiple cycles using round-robin input priority.
- Sits upstream of crossbar_one_hot_seq.
  - Drives its i_cmd and i_en.
  - Tells the source-data stage which inputs to present each cycle.

Parameters:
- NUM_INPUT_DATA, 16, number of crossbar inputs; power of 2.
- NUM_OUTPUT_DATA, 16, number of crossbar outputs; power of 2.
- TOTAL_COMMAND, NUM_INPUT_DATA*NUM_OUTPUT_DATA, localparam; command width.
- PTR_WIDTH, log2(NUM_INPUT_DATA), localparam; round-robin pointer width.

Ports:
- CLK  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_req_valid  input  1  batch request valid.
- i_req_mask  input  TOTAL_COMMAND  bit i*NUM_OUTPUT_DATA+j = input i requests output j; multicast allowed.
- o_req_ready  output  1  batch accepted when i_req_valid & o_req_ready at a clock edge.
- i_out_ready  input  1  downstream may accept a command this cycle.
- o_cmd  output  TOTAL_COMMAND  one-hot command, same bit layout as i_req_mask.
- o_cmd_valid  output  1  o_cmd valid; drives crossbar i_en.
- o_src_grant  output  NUM_INPUT_DATA  inputs whose data must be presented with this command.
- o_batch_done  output  1  one-cycle pulse coincident with the last command of a batch.
- o_busy  output  1  batch pending.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; pending=0; rr_ptr=0.
  - o_cmd=0, o_cmd_valid=0, o_src_grant=0, o_batch_done=0, o_busy=0.
- States: IDLE, ISSUE.
- o_req_ready = (state==IDLE), decoded from the state register.
- IDLE: on handshake, pending<=i_req_mask and go to ISSUE. An all-zero mask is accepted, issues no command, and is handled in ISSUE as below.
- ISSUE, combinational grant:
  - used=0.
  - For k=0..N_IN-1: idx=(rr_ptr+k) mod N_IN. Grant idx if pending row idx is nonzero and (row & used)==0; then used|=row.
  - A request is granted atomically (whole mask) or not at all.
- ISSUE edge with i_out_ready=1 and any grant:
  - o_cmd<=granted rows (others zero); o_src_grant<=grant vector; o_cmd_valid<=1.
  - Clear granted rows from pending.
  - rr_ptr<=(first granted idx in scan order + 1) mod N_IN.
  - If pending becomes empty: o_batch_done<=1 and state<=IDLE.
- ISSUE edge with i_out_ready=0: o_cmd_valid<=0, o_cmd<=0, o_src_grant<=0; pending and rr_ptr hold.
- ISSUE with pending==0 (empty batch): next edge returns to IDLE and pulses o_batch_done with o_cmd_valid=0.
- Otherwise o_cmd_valid, o_batch_done, o_cmd and o_src_grant return to 0 at the next edge.
- Latency: handshake at edge E0; first command registered at E1.
- A conflict-free batch (no shared output column) issues in exactly one command cycle.
- Batch of B rows all targeting a single common output issues in B cycles.
- Back-to-back: o_req_ready is high in the cycle o_batch_done is high, so a new batch can be accepted at the following edge (zero bubble).
- rr_ptr persists across batches; it is cleared only by reset.
- o_busy = (state==ISSUE).
- Reset asserted mid-batch: pending is discarded, outputs clear immediately, and no done pulse is issued.

Decomposition:
- Shared package holds:
  - NUM_INPUT_DATA/NUM_OUTPUT_DATA defaults.
  - The cmd bit-index function (i*NUM_OUTPUT_DATA+j).
  - State encoding constants, IDLE=0 and ISSUE=1.
- One sub-module, rr_conflict_arbiter: combinational scan taking pending, rr_ptr, and producing grant, granted_cmd and next_ptr.
- FSM, registers and handshake stay in the top module.

Test Plan:
- Permutation: input i -> output (15-i), valid 1 cycle after reset.
  - o_cmd_valid=1 exactly one cycle after handshake.
  - o_src_grant=16'hFFFF; o_cmd equals mask; o_batch_done=1 same cycle.
- Full conflict: inputs 0..3 all -> output 5, rr_ptr=0.
  - 4 command cycles with grants 1,2,4,8 in order, each o_cmd row 0x0020.
  - done on the 4th cycle; rr_ptr=4 after.
- Multicast overlap: in0 mask 0x0003, in1 mask 0x0002, in2 mask 0x0100.
  - Cycle1 grant=0x5; cycle2 grant=0x2 with done.
- Stall: full-conflict batch with i_out_ready=0 for cycles 2-3.
  - o_cmd_valid=0 during the stall; the grant sequence resumes unchanged; total 4 issued.
- Empty batch followed immediately by a permutation batch.
  - Done pulse with o_cmd_valid=0; second batch accepted at the next edge; its command appears 1 cycle later.
- Reset mid-batch: full conflict, assert rst after the 2nd command.
  - All outputs 0 asynchronously; after release o_req_ready=1 and rr_ptr=0 (next conflict batch grants input 0 first).
